// File: rtl/gray_cnt_pkg.sv
// Shared types and helpers for the Gray up/down counter.
// Width-generic helpers work on 32-bit vectors; callers cast to their width.
package gray_cnt_pkg;

  localparam int CNT_MAX_WID = 32;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  // All-ones value of a given width (the counter's upper limit).
  function automatic logic [CNT_MAX_WID-1:0] max_of(input int wid);
    logic [CNT_MAX_WID-1:0] m;
    m = '0;
    for (int i = 0; i < CNT_MAX_WID; i++) begin
      if (i < wid) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CNT_MAX_WID-1:0] bin2gray(input logic [CNT_MAX_WID-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input converts correctly: upper bits stay zero.
  function automatic logic [CNT_MAX_WID-1:0] gray2bin(input logic [CNT_MAX_WID-1:0] g);
    logic [CNT_MAX_WID-1:0] b;
    b[CNT_MAX_WID-1] = g[CNT_MAX_WID-1];
    for (int i = CNT_MAX_WID - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_bin_conv.sv
// Pure combinational binary-to-Gray converter feeding the Gray count flop.
module gray_bin_conv
  import gray_cnt_pkg::*;
#(
  parameter int WID = 4
) (
  input  logic [WID-1:0] bin_i,
  output logic [WID-1:0] gray_o
);

  // Convert through the shared package helper so there is one definition.
  always_comb begin
    gray_o = WID'(bin2gray(CNT_MAX_WID'(bin_i)));
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Parametrised synchronous Gray up/down counter with load, wrap/saturate,
// terminal count and overflow pulse. Count is registered straight from the
// Gray conversion of the next binary state, so it never glitches.
// Optional macro GRAY_CNT_CHECK_EN adds a sticky gray_err single-bit-change
// checker on the Count output.
module gray_updown_counter
  import gray_cnt_pkg::*;
#(
  parameter int          DATA_WID  = 4,
  parameter bit          WRAP_MODE = 1'b1,
  parameter int unsigned RST_VAL   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [DATA_WID-1:0] load_val,
  output logic [DATA_WID-1:0] Count,
  output logic [DATA_WID-1:0] Bin_Count,
  output logic                tc,
  output logic                ovf
`ifdef GRAY_CNT_CHECK_EN
  ,
  output logic                gray_err
`endif
);

  localparam logic [DATA_WID-1:0] MAX_BIN  = DATA_WID'(max_of(DATA_WID));
  localparam logic [DATA_WID-1:0] ONE      = DATA_WID'(1);
  localparam logic [DATA_WID-1:0] RST_BIN  = DATA_WID'(RST_VAL);
  localparam logic [DATA_WID-1:0] RST_GRAY = DATA_WID'(bin2gray(CNT_MAX_WID'(RST_BIN)));

  logic [DATA_WID-1:0] bin_q, bin_d;
  logic [DATA_WID-1:0] count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                at_limit, limit_evt;
  dir_t                dir;

  // Limit event: a step that would cross MAX going up or 0 going down.
  always_comb begin
    dir       = dir_t'(up_dn);
    at_limit  = (dir == DIR_UP) ? (bin_q == MAX_BIN) : (bin_q == '0);
    limit_evt = en & ~load & at_limit;
  end

  assign tc = limit_evt;

  // Next binary state: load beats step; saturate mode holds at the limit.
  always_comb begin
    bin_d = bin_q;
    ovf_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      ovf_d = limit_evt;
      if (limit_evt && !WRAP_MODE) begin
        bin_d = bin_q;
      end else if (dir == DIR_UP) begin
        bin_d = bin_q + ONE;
      end else begin
        bin_d = bin_q - ONE;
      end
    end
  end

  gray_bin_conv #(
    .WID(DATA_WID)
  ) u_next_gray (
    .bin_i (bin_d),
    .gray_o(count_d)
  );

  // State registers; reset abandons any step and clears the overflow pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q   <= RST_BIN;
      count_q <= RST_GRAY;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Count     = count_q;
  assign Bin_Count = bin_q;
  assign ovf       = ovf_q;

`ifdef GRAY_CNT_CHECK_EN
  logic [DATA_WID-1:0] prev_count_q, count_diff;
  logic                step_q, err_q, err_d, multi_bit;

  // More than one bit changed after an ordinary (non-load) cycle is an error.
  always_comb begin
    count_diff = prev_count_q ^ count_q;
    multi_bit  = (count_diff & (count_diff - ONE)) != '0;
    err_d      = err_q | (step_q & multi_bit);
  end

  // Previous Count, whether the last edge was an ordinary one, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count_q <= RST_GRAY;
      step_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_count_q <= count_q;
      step_q       <= ~load;
      err_q        <= err_d;
    end
  end

  assign gray_err = err_q;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: one wrapping and one saturating instance
// share the same stimulus and are checked every cycle against a model.
module tb_gray_updown_counter;

  localparam int MAXV = 15;

  logic       clk;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] count_w, bin_w, count_s, bin_s;
  logic       tc_w, ovf_w, tc_s, ovf_s;
`ifdef GRAY_CNT_CHECK_EN
  logic       gerr_w, gerr_s;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state, index 0 = wrap instance, 1 = saturate instance.
  int m_bin [2];
  bit m_ovf [2];

  gray_updown_counter #(.DATA_WID(4), .WRAP_MODE(1'b1), .RST_VAL(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Count(count_w), .Bin_Count(bin_w), .tc(tc_w), .ovf(ovf_w)
`ifdef GRAY_CNT_CHECK_EN
    , .gray_err(gerr_w)
`endif
  );

  gray_updown_counter #(.DATA_WID(4), .WRAP_MODE(1'b0), .RST_VAL(0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Count(count_s), .Bin_Count(bin_s), .tc(tc_s), .ovf(ovf_s)
`ifdef GRAY_CNT_CHECK_EN
    , .gray_err(gerr_s)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, settle 1 time unit.
  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv);
    reset = r; en = e; up_dn = u; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Model: reset > load > enabled step; at a limit wrap or hold and flag ovf.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int  nb;
      bit  no;
      bit  lim;
      nb  = m_bin[k];
      no  = 1'b0;
      lim = (up_dn && m_bin[k] == MAXV) || (!up_dn && m_bin[k] == 0);
      if (reset) nb = 0;
      else if (load) nb = int'(load_val);
      else if (en) begin
        no = lim;
        if (!(lim && k == 1)) nb = (m_bin[k] + (up_dn ? 1 : -1) + 16) % 16;
      end
      m_bin[k] <= nb;
      m_ovf[k] <= no;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      bit exp_tc_w, exp_tc_s;
      exp_tc_w = en && !load && ((up_dn && m_bin[0] == MAXV) || (!up_dn && m_bin[0] == 0));
      exp_tc_s = en && !load && ((up_dn && m_bin[1] == MAXV) || (!up_dn && m_bin[1] == 0));
      check("w_bin",   32'(bin_w),   32'(m_bin[0]));
      check("w_count", 32'(count_w), 32'(gray_of(m_bin[0])));
      check("w_ovf",   32'(ovf_w),   32'(m_ovf[0]));
      check("w_tc",    32'(tc_w),    32'(exp_tc_w));
      check("s_bin",   32'(bin_s),   32'(m_bin[1]));
      check("s_count", 32'(count_s), 32'(gray_of(m_bin[1])));
      check("s_ovf",   32'(ovf_s),   32'(m_ovf[1]));
      check("s_tc",    32'(tc_s),    32'(exp_tc_s));
`ifdef GRAY_CNT_CHECK_EN
      check("w_gray_err", 32'(gerr_w), 32'(0));
      check("s_gray_err", 32'(gerr_s), 32'(0));
`endif
    end
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0011; exp_g[2] = 4'b0010; exp_g[3] = 4'b0110;
    m_bin[0] = 0; m_bin[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 4'd0;

    // Reset held two cycles
    @(posedge clk); @(posedge clk); #1;
    chk_on = 1'b1;
    check("rst_count", 32'(count_w), 32'h0);
    check("rst_bin",   32'(bin_w),   32'h0);
    check("rst_ovf",   32'(ovf_w),   32'h0);

    // Count up 0..4
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, 0);
      check("up_count", 32'(count_w), 32'(exp_g[i]));
      check("up_bin",   32'(bin_w),   32'(i + 1));
      check("up_ovf",   32'(ovf_w),   32'h0);
    end

    // Up to 15, then wrap / saturate
    repeat (11) drive(0, 1, 1, 0, 0);
    check("max_count", 32'(count_w), 32'b1000);
    check("max_tc",    32'(tc_w),    32'h1);
    drive(0, 1, 1, 0, 0);
    check("wrap_count", 32'(count_w), 32'h0);
    check("wrap_ovf",   32'(ovf_w),   32'h1);
    check("sat_hi_bin", 32'(bin_s),   32'hf);
    check("sat_hi_ovf", 32'(ovf_s),   32'h1);
    drive(0, 1, 1, 0, 0);
    check("wrap_ovf_once", 32'(ovf_w), 32'h0);
    check("wrap_bin1",     32'(bin_w), 32'h1);
    check("sat_ovf_held",  32'(ovf_s), 32'h1);

    // Load 1 then saturate down
    drive(0, 0, 0, 1, 4'd1);
    check("ld1_bin", 32'(bin_s), 32'h1);
    check("ld1_ovf", 32'(ovf_s), 32'h0);
    drive(0, 1, 0, 0, 0);
    check("sd1_bin", 32'(bin_s), 32'h0);
    check("sd1_ovf", 32'(ovf_s), 32'h0);
    drive(0, 1, 0, 0, 0);
    check("sd2_bin", 32'(bin_s), 32'h0);
    check("sd2_ovf", 32'(ovf_s), 32'h1);
    check("wd2_bin", 32'(bin_w), 32'hf);
    drive(0, 1, 0, 0, 0);
    check("sd3_count", 32'(count_s), 32'h0);
    check("sd3_ovf",   32'(ovf_s),   32'h1);
    drive(0, 0, 0, 0, 0);
    check("hold_ovf", 32'(ovf_s), 32'h0);
    // Reversal at the low limit is an ordinary step
    drive(0, 1, 1, 0, 0);
    check("rev_bin", 32'(bin_s), 32'h1);
    check("rev_ovf", 32'(ovf_s), 32'h0);

    // Load beats enable
    drive(0, 1, 1, 1, 4'd5);
    check("ldp_bin",   32'(bin_w),   32'h5);
    check("ldp_count", 32'(count_w), 32'b0111);
    drive(0, 1, 1, 0, 0);
    check("ldp_up_bin",   32'(bin_w),   32'h6);
    check("ldp_up_count", 32'(count_w), 32'b0101);

    // Reset mid-run, then reverse direction
    drive(0, 0, 0, 1, 4'd0);
    repeat (3) drive(0, 1, 1, 0, 0);
    check("mid_count", 32'(count_w), 32'b0010);
    drive(1, 1, 1, 0, 0);
    check("mid_rst_count", 32'(count_w), 32'h0);
    check("mid_rst_ovf",   32'(ovf_w),   32'h0);
    repeat (2) drive(0, 1, 1, 0, 0);
    check("rev_up_count", 32'(count_w), 32'b0011);
    drive(0, 1, 0, 0, 0);
    check("rev_dn_count", 32'(count_w), 32'b0001);

    // Reversal at the high limit while saturated
    drive(0, 0, 0, 1, 4'd15);
    drive(0, 1, 1, 0, 0);
    check("hi_sat_ovf", 32'(ovf_s), 32'h1);
    drive(0, 1, 0, 0, 0);
    check("hi_rev_bin", 32'(bin_s), 32'he);
    check("hi_rev_ovf", 32'(ovf_s), 32'h0);
    check("hi_w_ovf",   32'(ovf_w), 32'h1);
    drive(0, 0, 0, 0, 0);

`ifdef GRAY_CNT_CHECK_EN
    // Random traffic must never trip the checker
    for (int i = 0; i < 200; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end
    drive(0, 0, 0, 0, 0);
    // Inject a two-bit Count change after an ordinary cycle
    chk_on = 1'b0;
    begin
      logic [3:0] bad;
      bad = dut_w.prev_count_q ^ 4'b0011;
      force dut_w.count_q = bad;
      drive(0, 0, 0, 0, 0);
      release dut_w.count_q;
    end
    check("gerr_set", 32'(gerr_w), 32'h1);
    repeat (3) drive(0, 1, 1, 0, 0);
    check("gerr_sticky", 32'(gerr_w), 32'h1);
    drive(1, 0, 0, 0, 0);
    check("gerr_clr", 32'(gerr_w), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
